// File: rtl/ltc2308_ctrl_if.sv
// Request/result bundle between on-chip logic and the LTC2308 controller.
// The requester is the master; the controller is the slave.
interface ltc2308_ctrl_if;
    logic        start;
    logic [5:0]  cfg;
    logic        busy;
    logic        data_valid;
    logic [11:0] data;
    logic [5:0]  data_cfg;

    modport master (
        output start, cfg,
        input  busy, data_valid, data, data_cfg
    );

    modport slave (
        input  start, cfg,
        output busy, data_valid, data, data_cfg
    );
endinterface

// File: rtl/ltc2308_ctrl.sv
// LTC2308 SAR ADC master: CONVST pulse, conversion wait, 12-bit SPI frame.
// Results carry the config word that selected them (one request behind).
module ltc2308_ctrl #(
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SCK_HALF      = 2
) (
    input  logic          clk,
    input  logic          rst,
    ltc2308_ctrl_if.slave bus,
    output logic          adc_convst,
    output logic          adc_sck,
    output logic          adc_sdi,
    input  logic          adc_sdo
);

    typedef enum logic [2:0] {
        IDLE,
        CONV_HI,
        CONV_WAIT,
        SHIFT,
        DONE
    } state_t;

    localparam logic [15:0] HI_LAST   = 16'(CONVST_CYCLES);
    localparam logic [15:0] WAIT_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(SCK_HALF - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  bit_cnt;
    logic [5:0]  cfg_sh;
    logic [5:0]  cfg_out;
    logic [5:0]  prev_cfg;
    logic [11:0] res_sh;

    // Sequencer: every output is a register updated by this one FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            cfg_sh          <= '0;
            cfg_out         <= '0;
            prev_cfg        <= '0;
            res_sh          <= '0;
            bus.busy        <= 1'b0;
            bus.data_valid  <= 1'b0;
            bus.data        <= '0;
            bus.data_cfg    <= '0;
            adc_convst      <= 1'b0;
            adc_sck         <= 1'b0;
            adc_sdi         <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        cfg_sh <= bus.cfg;
                        cnt    <= '0;
                        state  <= CONV_HI;
                    end
                end
                CONV_HI: begin
                    bus.busy <= 1'b1;
                    if (cnt == HI_LAST) begin
                        adc_convst <= 1'b0;
                        cnt        <= '0;
                        state      <= CONV_WAIT;
                    end else begin
                        adc_convst <= 1'b1;
                        cnt        <= cnt + 16'd1;
                    end
                end
                CONV_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        adc_sdi <= cfg_sh[5];
                        cfg_out <= {cfg_sh[4:0], 1'b0};
                        res_sh  <= '0;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else if (!adc_sck) begin
                        cnt     <= '0;
                        adc_sck <= 1'b1;
                    end else begin
                        cnt     <= '0;
                        adc_sck <= 1'b0;
                        res_sh  <= {res_sh[10:0], adc_sdo};
                        if (bit_cnt == 4'd11) begin
                            adc_sdi <= 1'b0;
                            state   <= DONE;
                        end else begin
                            adc_sdi <= cfg_out[5];
                            cfg_out <= {cfg_out[4:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    bus.data_valid <= 1'b1;
                    bus.data       <= res_sh;
                    bus.data_cfg   <= prev_cfg;
                    prev_cfg       <= cfg_sh;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: pin-level LTC2308 model plus request-level
// reference; default and overridden-timing instances side by side.
module tb_ltc2308_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start_v;
    logic [5:0]  cfg_v [2];
    logic [1:0]  busy_v, dv_v, convst_v, sck_v, sdi_v, sdo_v;
    logic [11:0] data_v [2];
    logic [5:0]  dcfg_v [2];

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    int          e0 [2];
    logic [11:0] exp_d [2];
    logic [5:0]  exp_c [2];
    logic [5:0]  adc_next [2];
    logic [5:0]  prev_ref [2];

    always #10 clk = ~clk;

    // Cycle index of the most recent rising edge
    always @(posedge clk) cyc++;

    // Board channel voltages: CH0=FFF, CH1=EEE ... CH7=888
    function automatic logic [11:0] chan_val(input logic [5:0] c);
        int ch;
        if (!c[5]) return 12'h000;
        ch = {c[3], c[2], c[4]};
        return 12'(12'hFFF - 12'h111 * ch);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ltc2308_ctrl_if bus ();

        assign bus.start  = start_v[g];
        assign bus.cfg    = cfg_v[g];
        assign busy_v[g]  = bus.busy;
        assign dv_v[g]    = bus.data_valid;
        assign data_v[g]  = bus.data;
        assign dcfg_v[g]  = bus.data_cfg;

        ltc2308_ctrl #(
            .CONVST_CYCLES (2),
            .CONV_CYCLES   (g == 0 ? 80 : 81),
            .SCK_HALF      (g == 0 ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .adc_convst (convst_v[g]),
            .adc_sck    (sck_v[g]),
            .adc_sdi    (sdi_v[g]),
            .adc_sdo    (sdo_v[g])
        );

        logic [5:0]  m_cfg   = 6'd0;
        logic [5:0]  pend    = 6'd0;
        logic        pend_ok = 1'b0;
        logic [5:0]  sh      = 6'd0;
        logic [11:0] res     = 12'd0;
        logic [11:0] sdi_rec = 12'd0;
        int          nsh     = 0;
        int          nfall   = 12;
        int          rises   = 0;
        int          pulses  = 0;
        int          hi      = 0;
        int          dvs     = 0;

        // ADC: converts on CONVST rise, latches a full 6-bit word per frame
        always @(posedge convst_v[g] or posedge sck_v[g] or negedge sck_v[g]) begin
            if (convst_v[g]) begin
                if (pend_ok) m_cfg = pend;
                pend_ok = 1'b0;
                res     = chan_val(m_cfg);
                nfall   = 0;
                nsh     = 0;
                pulses++;
            end else if (sck_v[g]) begin
                sh      = {sh[4:0], sdi_v[g]};
                sdi_rec = {sdi_rec[10:0], sdi_v[g]};
                nsh++;
                rises++;
                if (nsh == 6) begin
                    pend    = sh;
                    pend_ok = 1'b1;
                end
            end else begin
                nfall++;
            end
        end

        assign sdo_v[g] = (nfall < 12) ? res[11 - nfall] : 1'b0;

        always @(posedge clk) begin
            if (convst_v[g]) hi++;
            if (dv_v[g]) dvs++;
        end
    end

    function automatic int get_rises(input int g);
        return (g == 1) ? g_dut[1].rises : g_dut[0].rises;
    endfunction

    function automatic int get_pulses(input int g);
        return (g == 1) ? g_dut[1].pulses : g_dut[0].pulses;
    endfunction

    function automatic int get_dvs(input int g);
        return (g == 1) ? g_dut[1].dvs : g_dut[0].dvs;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Request-level reference: result uses the last fully shifted word,
    // tag is the word of the previous accepted request since reset
    task automatic predict(input int g, input logic [5:0] c);
        exp_d[g]    = chan_val(adc_next[g]);
        exp_c[g]    = prev_ref[g];
        adc_next[g] = c;
        prev_ref[g] = c;
    endtask

    task automatic issue(input int g, input logic [5:0] c);
        predict(g, c);
        start_v[g] = 1'b1;
        cfg_v[g]   = c;
        @(negedge clk);
        start_v[g] = 1'b0;
        e0[g]      = cyc;
    endtask

    task automatic wait_done(input int g, input int lat, input bit nxt,
                             input logic [5:0] nc);
        int n = 0;
        while (!dv_v[g] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!dv_v[g]) begin
            check("dv_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", cyc - e0[g], lat);
        check("data", data_v[g], exp_d[g]);
        check("data_cfg", dcfg_v[g], exp_c[g]);
        if (nxt) begin
            predict(g, nc);
            start_v[g] = 1'b1;
            cfg_v[g]   = nc;
        end
        @(negedge clk);
        check("busy_dv_after", {busy_v[g], dv_v[g]}, 0);
        if (nxt) begin
            start_v[g] = 1'b0;
            e0[g]      = cyc;
        end
    endtask

    initial begin
        int r0, h0, p0, d0, n;
        logic [5:0]  c;
        logic [5:0]  save_next;
        rst       = 1'b1;
        start_v   = '0;
        cfg_v[0]  = '0;
        cfg_v[1]  = '0;
        for (int i = 0; i < 2; i++) begin
            adc_next[i] = '0;
            prev_ref[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ctl", {busy_v[i], dv_v[i], convst_v[i], sck_v[i], sdi_v[i]}, 0);
            check("rst_data", {data_v[i], dcfg_v[i]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        r0 = get_rises(0);
        h0 = g_dut[0].hi;
        issue(0, 6'b100000);
        wait_done(0, 132, 0, 6'd0);
        check("sck_rises", get_rises(0) - r0, 12);
        check("convst_width", g_dut[0].hi - h0, 2);
        check("sdi_bits", g_dut[0].sdi_rec, {6'b100000, 6'b000000});

        issue(0, 6'b110000);
        wait_done(0, 132, 1, 6'b100000);
        wait_done(0, 132, 0, 6'd0);
        check("ch1_data", data_v[0], 12'hEEE);

        p0 = get_pulses(0);
        d0 = get_dvs(0);
        issue(0, 6'b101000);
        repeat (9) @(negedge clk);
        start_v[0] = 1'b1;
        cfg_v[0]   = 6'b111100;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (89) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 132, 0, 6'd0);
        repeat (20) @(negedge clk);
        check("lockout_convst", get_pulses(0) - p0, 1);
        check("lockout_dv", get_dvs(0) - d0, 1);

        save_next = adc_next[0];
        issue(0, 6'b100100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_conv_hi", {convst_v[0], busy_v[0], sck_v[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        adc_next[0] = save_next;
        prev_ref[0] = '0;
        issue(0, 6'b110100);
        wait_done(0, 132, 0, 6'd0);

        save_next = adc_next[0];
        d0 = get_dvs(0);
        r0 = get_rises(0);
        issue(0, 6'b101100);
        n = 0;
        while (get_rises(0) - r0 < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_5th_rise", get_rises(0) - r0, 5);
        #3 rst = 1'b1;
        #1 check("rst_shift", {sck_v[0], busy_v[0], convst_v[0], sdi_v[0]}, 0);
        r0 = get_rises(0);
        repeat (5) @(negedge clk);
        check("no_sck_in_rst", get_rises(0) - r0, 0);
        rst = 1'b0;
        adc_next[0] = save_next;
        prev_ref[0] = '0;
        repeat (150) @(negedge clk);
        check("no_dv_aborted", get_dvs(0) - d0, 0);
        issue(0, 6'b111000);
        wait_done(0, 132, 0, 6'd0);

        for (int k = 0; k < 20; k++) begin
            c = 6'($urandom);
            if ($urandom_range(3) != 0) c[5] = 1'b1;
            if ($urandom_range(2) == 0) begin
                issue(0, c);
                wait_done(0, 132, 1, 6'($urandom));
                wait_done(0, 132, 0, 6'd0);
            end else begin
                issue(0, c);
                wait_done(0, 132, 0, 6'd0);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            check("data_hold", {data_v[0], dcfg_v[0]}, {exp_d[0], exp_c[0]});
        end

        for (int k = 0; k < 4; k++) begin
            c = {1'b1, 5'($urandom)};
            issue(1, c);
            wait_done(1, 109, 0, 6'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
